tick_irq_gen: RTL and testbench

- Parametrised, multi-channel successor to the single fixed 125 Hz interrupt timer in the board top level.
- Each channel has a runtime-loadable period, periodic or one-shot mode, a sticky pending latch with acknowledge, per-channel mask and an overrun flag.
- Sits beside yrv_mcu in board top levels. Channel 0 drives ei_req; the other channels serve software timebases and display refresh.
- Software controls the block through port registers.

---
 rtl/tick_irq_gen.sv | 119 +++++++++++
 tb/tb_tick_irq_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tick_irq_gen.sv
// Multi-channel interval timer: each channel counts a latched period and raises tick/pending/overrun.
// irq is the OR of every channel's pending flag gated by its mask.
module tick_irq_gen #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         enable,
    input  logic [N_CH-1:0]         start,
    input  logic [N_CH-1:0]         mode,
    input  logic [N_CH*CNT_W-1:0]   period,
    input  logic [N_CH-1:0]         ack,
    input  logic [N_CH-1:0]         mask,
    output logic [N_CH-1:0]         tick,
    output logic [N_CH-1:0]         pend,
    output logic [N_CH-1:0]         overrun,
    output logic [N_CH-1:0]         running,
    output logic                    irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            state_e           state_q, state_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic [CNT_W-1:0] per_q, per_d;
            logic             mode_q, mode_d;
            logic             tick_q;
            logic             pend_q, pend_d;
            logic             ovr_q, ovr_d;
            logic             run_q;
            logic [CNT_W-1:0] per_in;
            logic             expire;

            assign per_in = period[g*CNT_W +: CNT_W];

            // Priority: enable low beats start, start beats a pending expiry.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                per_d   = per_q;
                mode_d  = mode_q;
                expire  = 1'b0;
                if (!enable[g]) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (start[g]) begin
                    per_d   = per_in;
                    mode_d  = mode[g];
                    cnt_d   = CNT_ZERO;
                    state_d = (per_in == CNT_ZERO) ? ST_IDLE : ST_RUN;
                end else if (state_q == ST_RUN) begin
                    if (cnt_q == per_q - CNT_ONE) begin
                        expire = 1'b1;
                        cnt_d  = CNT_ZERO;
                        if (mode_q) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            // A simultaneous expiry and ack leaves pend set and overrun clear.
            always_comb begin
                pend_d = pend_q;
                ovr_d  = ovr_q;
                if (expire) begin
                    ovr_d  = ack[g] ? 1'b0 : (ovr_q | pend_q);
                    pend_d = 1'b1;
                end else if (ack[g]) begin
                    pend_d = 1'b0;
                    ovr_d  = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= CNT_ZERO;
                    per_q   <= CNT_ZERO;
                    mode_q  <= 1'b0;
                    tick_q  <= 1'b0;
                    pend_q  <= 1'b0;
                    ovr_q   <= 1'b0;
                    run_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    per_q   <= per_d;
                    mode_q  <= mode_d;
                    tick_q  <= expire;
                    pend_q  <= pend_d;
                    ovr_q   <= ovr_d;
                    run_q   <= (state_d == ST_RUN);
                end
            end

            assign tick[g]    = tick_q;
            assign pend[g]    = pend_q;
            assign overrun[g] = ovr_q;
            assign running[g] = run_q;
        end
    endgenerate

    assign irq = |(pend & mask);

endmodule

// File: tb/tb_tick_irq_gen.sv
// Bench for tick_irq_gen: directed scenarios plus random traffic, checked every cycle
// against a countdown-based model of each channel.
module tb_tick_irq_gen;

    localparam int N_CH  = 4;
    localparam int CNT_W = 24;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N_CH-1:0]       enable, start, mode, ack, mask;
    logic [N_CH*CNT_W-1:0] period;
    logic [N_CH-1:0]       tick, pend, overrun, running;
    logic                  irq;

    tick_irq_gen #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .start   (start),
        .mode    (mode),
        .period  (period),
        .ack     (ack),
        .mask    (mask),
        .tick    (tick),
        .pend    (pend),
        .overrun (overrun),
        .running (running),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int tick_cnt[N_CH];

    // Model: each active channel counts down the cycles remaining to its next expiry.
    bit          m_act[N_CH];
    bit          m_oneshot[N_CH];
    int unsigned m_rem[N_CH];
    int unsigned m_per[N_CH];
    logic [N_CH-1:0] e_tick, e_pend, e_ovr, e_run;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_edge();
        for (int i = 0; i < N_CH; i++) begin
            int unsigned p;
            bit expiry;
            p = int'(period[i*CNT_W +: CNT_W]);
            expiry = 1'b0;
            if (reset) begin
                m_act[i] = 0; m_oneshot[i] = 0; m_rem[i] = 0; m_per[i] = 0;
                e_tick[i] = 0; e_pend[i] = 0; e_ovr[i] = 0; e_run[i] = 0;
                continue;
            end
            if (!enable[i]) begin
                m_act[i] = 0;
            end else if (start[i]) begin
                m_per[i]     = p;
                m_rem[i]     = p;
                m_oneshot[i] = mode[i];
                m_act[i]     = (p != 0);
            end else if (m_act[i]) begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    expiry = 1'b1;
                    if (m_oneshot[i]) m_act[i] = 0;
                    else              m_rem[i] = m_per[i];
                end
            end
            e_tick[i] = expiry;
            if (expiry) begin
                e_ovr[i]  = ack[i] ? 1'b0 : (e_ovr[i] | e_pend[i]);
                e_pend[i] = 1'b1;
            end else if (ack[i]) begin
                e_pend[i] = 1'b0;
                e_ovr[i]  = 1'b0;
            end
            e_run[i] = m_act[i];
        end
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        for (int i = 0; i < N_CH; i++) tick_cnt[i] += int'(tick[i]);
        check("tick",    32'(tick),    32'(e_tick));
        check("pend",    32'(pend),    32'(e_pend));
        check("overrun", 32'(overrun), 32'(e_ovr));
        check("running", 32'(running), 32'(e_run));
        check("irq",     32'(irq),     32'(|(e_pend & mask)));
        start = '0;
        ack   = '0;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < N_CH; i++) tick_cnt[i] = 0;
    endtask

    task automatic kick(input int ch, input int unsigned p, input bit md);
        period[ch*CNT_W +: CNT_W] = p[CNT_W-1:0];
        mode[ch]  = md;
        start[ch] = 1'b1;
    endtask

    initial begin
        reset = 1'b1; enable = '0; start = '0; mode = '0; ack = '0; mask = '0; period = '0;
        clr_cnt();
        steps(2);
        check("rst_outs", 32'({tick, pend, overrun, running}), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        enable = '1;

        // Periodic, period 4: ticks after edges 4, 8, 12.
        mask = 4'b0001;
        kick(0, 4, 1'b0);
        step();
        clr_cnt();
        steps(3);
        check("p4_no_early_tick", 32'(tick_cnt[0]), 32'd0);
        steps(9);
        check("p4_ticks", 32'(tick_cnt[0]), 32'd3);
        mask = '0; #1;
        check("irq_masked", 32'(irq), 32'd0);
        mask = 4'b0001; #1;
        check("irq_unmasked", 32'(irq), 32'd1);

        // One-shot, period 3, then re-arm.
        ack[0] = 1'b1;
        kick(0, 3, 1'b1);
        step();
        clr_cnt();
        steps(3);
        check("os_tick", 32'(tick_cnt[0]), 32'd1);
        check("os_run_off", 32'(running[0]), 32'd0);
        steps(20);
        check("os_single", 32'(tick_cnt[0]), 32'd1);
        kick(0, 3, 1'b1);
        steps(4);
        check("os_rearm", 32'(tick_cnt[0]), 32'd2);

        // Collision of ack with expiry, then overrun, then a plain ack.
        kick(1, 4, 1'b0);
        steps(8);
        ack[1] = 1'b1;
        step();
        check("coll_pend", 32'(pend[1]), 32'd1);
        check("coll_ovr", 32'(overrun[1]), 32'd0);
        steps(4);
        check("ovr_set", 32'(overrun[1]), 32'd1);
        ack[1] = 1'b1;
        step();
        check("ack_pend", 32'(pend[1]), 32'd0);
        check("ack_ovr", 32'(overrun[1]), 32'd0);

        // Period 0 never runs; bus changes without start are ignored.
        kick(2, 0, 1'b0);
        step();
        clr_cnt();
        steps(50);
        check("p0_ticks", 32'(tick_cnt[2]), 32'd0);
        period[2*CNT_W +: CNT_W] = 24'd2;
        steps(10);
        check("p0_bus_ticks", 32'(tick_cnt[2] + int'(running[2])), 32'd0);

        // Enable drop exactly at the expiry edge.
        kick(3, 5, 1'b0);
        steps(10);
        enable[3] = 1'b0;
        step();
        check("endrop_tick", 32'(tick[3]), 32'd0);
        check("endrop_pend", 32'(pend[3]), 32'd1);
        enable[3] = 1'b1;
        kick(3, 5, 1'b0);
        steps(6);

        // Reset in the middle of counting.
        kick(0, 6, 1'b0);
        kick(1, 3, 1'b0);
        steps(5);
        reset = 1'b1;
        step();
        check("midrst_outs", 32'({tick, pend, overrun, running}), 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        reset = 1'b0;

        // Four independent periods started together.
        kick(0, 2, 1'b0); kick(1, 3, 1'b0); kick(2, 5, 1'b0); kick(3, 7, 1'b0);
        step();
        clr_cnt();
        for (int k = 0; k < 70; k++) begin
            mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) ack = 4'($urandom_range(0, 15));
            step();
        end

        // Random traffic.
        for (int k = 0; k < 2000; k++) begin
            reset = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < N_CH; i++) begin
                enable[i] = ($urandom_range(0, 39) != 0);
                ack[i]    = ($urandom_range(0, 9) == 0);
                mask[i]   = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 24) == 0) begin
                    int unsigned p;
                    case ($urandom_range(0, 9))
                        0:       p = 0;
                        1:       p = 32'hFF_FFFF;
                        default: p = $urandom_range(1, 9);
                    endcase
                    kick(i, p, 1'($urandom_range(0, 1)));
                end
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
